// File: rtl/reg16_loader_pkg.sv
// Sizes and state encoding shared by the loader, the 16x8 scan stage and the bench.
package reg16_loader_pkg;

    localparam int DEPTH  = 16;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;

    localparam logic [WIDTH-1:0]  PAD_VAL   = 8'h00;
    localparam logic [ADDR_W-1:0] LAST_IDX  = 4'd15;
    localparam logic [ADDR_W-1:0] IDX_ZERO  = 4'd0;
    localparam logic [ADDR_W-1:0] IDX_ONE   = 4'd1;
    localparam logic [ADDR_W:0]   CNT_ZERO  = 5'd0;
    localparam logic [ADDR_W:0]   CNT_ONE   = 5'd1;
    localparam logic [WIDTH-1:0]  DATA_ZERO = 8'h00;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_LOAD  = 3'd1;
    localparam state_t S_PAD   = 3'd2;
    localparam state_t S_FLUSH = 3'd3;
    localparam state_t S_KICK  = 3'd4;
    localparam state_t S_WAIT  = 3'd5;
    localparam state_t S_FIN   = 3'd6;

    function automatic logic is_last_idx(input logic [ADDR_W-1:0] idx);
        return idx == LAST_IDX;
    endfunction

endpackage

// File: rtl/reg16_loader.sv
// Streams one frame of bytes into the 16x8 register file, pads short frames,
// kicks the scan stage and waits for it before accepting the next frame.
module reg16_loader
    import reg16_loader_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [WIDTH-1:0]  w_data,
    output logic              go,
    input  logic              done_in,
    output logic              busy,
    output logic              load_done,
    output logic [ADDR_W:0]   count
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                w_en_q, w_en_d;
    logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [WIDTH-1:0]    w_data_q, w_data_d;

    logic in_ready_s, busy_s, go_s, load_done_s, accept_s;

    assign accept_s = in_valid & in_ready_s;

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a full frame ends at the 16th byte whether or not in_last is set.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
                else       state_d = S_IDLE;
            end
            S_LOAD: begin
                if (accept_s) begin
                    if (is_last_idx(idx_q)) state_d = S_FLUSH;
                    else if (in_last)       state_d = S_PAD;
                    else                    state_d = S_LOAD;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_PAD: begin
                if (is_last_idx(idx_q)) state_d = S_FLUSH;
                else                    state_d = S_PAD;
            end
            S_FLUSH: state_d = S_KICK;
            S_KICK:  state_d = S_WAIT;
            S_WAIT: begin
                if (done_in) state_d = S_FIN;
                else         state_d = S_WAIT;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        in_ready_s  = 1'b0;
        busy_s      = 1'b1;
        go_s        = 1'b0;
        load_done_s = 1'b0;
        case (state_q)
            S_IDLE:  busy_s      = 1'b0;
            S_LOAD:  in_ready_s  = 1'b1;
            S_KICK:  go_s        = 1'b1;
            S_FIN:   load_done_s = 1'b1;
            S_PAD, S_FLUSH, S_WAIT: busy_s = 1'b1;
            default: busy_s      = 1'b0;
        endcase
    end

    // Write-port and counter next values; idx parks at the last entry until the next start.
    always_comb begin
        idx_d    = idx_q;
        count_d  = count_q;
        w_en_d   = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = IDX_ZERO;
                    count_d = CNT_ZERO;
                end else begin
                    idx_d   = idx_q;
                    count_d = count_q;
                end
            end
            S_LOAD: begin
                if (accept_s) begin
                    w_en_d   = 1'b1;
                    w_addr_d = idx_q;
                    w_data_d = in_data;
                    count_d  = count_q + CNT_ONE;
                    if (is_last_idx(idx_q)) idx_d = idx_q;
                    else                    idx_d = idx_q + IDX_ONE;
                end else begin
                    w_en_d = 1'b0;
                end
            end
            S_PAD: begin
                w_en_d   = 1'b1;
                w_addr_d = idx_q;
                w_data_d = PAD_VAL;
                if (is_last_idx(idx_q)) idx_d = idx_q;
                else                    idx_d = idx_q + IDX_ONE;
            end
            default: w_en_d = 1'b0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            idx_q    <= IDX_ZERO;
            count_q  <= CNT_ZERO;
            w_en_q   <= 1'b0;
            w_addr_q <= IDX_ZERO;
            w_data_q <= DATA_ZERO;
        end else begin
            idx_q    <= idx_d;
            count_q  <= count_d;
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign busy      = busy_s;
    assign go        = go_s;
    assign load_done = load_done_s;
    assign w_en      = w_en_q;
    assign w_addr    = w_addr_q;
    assign w_data    = w_data_q;
    assign count     = count_q;

endmodule

// File: tb/tb_reg16_loader.sv
// Scoreboard bench for reg16_loader: expected writes are queued as bytes are
// driven and popped by a monitor whenever the write strobe is seen.
module tb_reg16_loader;
    import reg16_loader_pkg::*;

    logic              Clk = 1'b0;
    logic              Rst, start, in_valid, in_last, done_in;
    logic [WIDTH-1:0]  in_data;
    logic              in_ready, w_en, go, busy, load_done;
    logic [ADDR_W-1:0] w_addr;
    logic [WIDTH-1:0]  w_data;
    logic [ADDR_W:0]   count;

    int checks = 0;
    int errors = 0;
    int writes_seen = 0;
    int go_seen = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_e;
    logic        prev_w_en = 1'b0;
    logic [3:0]  prev_addr = 4'd0;

    reg16_loader dut (
        .Clk(Clk), .Rst(Rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .w_en(w_en), .w_addr(w_addr),
        .w_data(w_data), .go(go), .done_in(done_in), .busy(busy),
        .load_done(load_done), .count(count)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Monitor: pop one expected write per strobe; go must follow the addr-15 strobe directly.
    initial begin
        forever begin
            @(negedge Clk);
            if (w_en) begin
                writes_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_write: got addr=%0d data=%02h, required no write", w_addr, w_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({w_addr, w_data} !== mon_e) begin
                        errors++;
                        $display("FAIL sb_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                                 w_addr, w_data, mon_e[11:8], mon_e[7:0]);
                    end
                end
            end
            if (go) begin
                go_seen++;
                checks++;
                if (!(prev_w_en && prev_addr == 4'd15 && !w_en)) begin
                    errors++;
                    $display("FAIL go_timing: prev_w_en=%0b prev_addr=%0d w_en=%0b, required 1/15/0",
                             prev_w_en, prev_addr, w_en);
                end
            end
            prev_w_en = w_en;
            prev_addr = w_addr;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic last, input int gap_max, output bit ok);
        int n;
        ok = 1'b1;
        repeat ($urandom_range(gap_max, 0)) tick();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) ok = 1'b0;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic complete_frame(input int done_delay, output int go_cyc, output int ld_cyc, output bit early_ld);
        int n;
        n = 0;
        early_ld = 1'b0;
        while (!go && n < 200) begin
            tick();
            n++;
        end
        go_cyc = (n >= 200) ? -1 : n;
        repeat (done_delay) begin
            tick();
            if (load_done || !busy) early_ld = 1'b1;
        end
        done_in = 1'b1;
        n = 0;
        while (!load_done && n < 200) begin
            tick();
            n++;
        end
        ld_cyc = (n >= 200) ? -1 : n;
        done_in = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({in_ready, w_en, go, busy, load_done, w_addr, w_data, count} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%0b wen=%0b go=%0b busy=%0b ld=%0b addr=%0d data=%02h cnt=%0d, required all 0",
                     in_ready, w_en, go, busy, load_done, w_addr, w_data, count);
        end
        Rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%0b rdy=%0b, required 0/0", busy, in_ready);
        end
    endtask

    task automatic test_full_frame();
        int w0, go_cyc, ld_cyc;
        bit ok, all_ok, early;
        logic [7:0] d;
        w0 = writes_seen;
        all_ok = 1'b1;
        start_frame();
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'(8'h10 + i);
            exp_q.push_back({4'(i), d});
            drive_byte(d, (i == DEPTH - 1), 0, ok);
            all_ok &= ok;
        end
        checks++;
        if (!all_ok || count !== 5'd16 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_count: got ok=%0b count=%0d rdy=%0b, required 1/16/0", all_ok, count, in_ready);
        end
        complete_frame(2, go_cyc, ld_cyc, early);
        checks++;
        if (go_cyc !== 1 || ld_cyc !== 1 || early) begin
            errors++;
            $display("FAIL full_handshake: got go_cyc=%0d ld_cyc=%0d early=%0b, required 1/1/0", go_cyc, ld_cyc, early);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || load_done !== 1'b0 || writes_seen - w0 !== 16 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL full_end: got busy=%0b ld=%0b writes=%0d left=%0d, required 0/0/16/0",
                     busy, load_done, writes_seen - w0, exp_q.size());
        end
    endtask

    task automatic test_pad();
        int w0, go_cyc, ld_cyc;
        bit ok, all_ok, early;
        logic [7:0] d;
        w0 = writes_seen;
        all_ok = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            d = (i < 5) ? 8'(8'hA0 + i) : PAD_VAL;
            exp_q.push_back({4'(i), d});
        end
        start_frame();
        for (int i = 0; i < 5; i++) begin
            d = 8'(8'hA0 + i);
            drive_byte(d, (i == 4), 0, ok);
            all_ok &= ok;
        end
        checks++;
        if (!all_ok || count !== 5'd5) begin
            errors++;
            $display("FAIL pad_count: got ok=%0b count=%0d, required 1/5", all_ok, count);
        end
        complete_frame(1, go_cyc, ld_cyc, early);
        checks++;
        if (go_cyc !== 12 || ld_cyc !== 1 || early || count !== 5'd5) begin
            errors++;
            $display("FAIL pad_handshake: got go_cyc=%0d ld_cyc=%0d early=%0b count=%0d, required 12/1/0/5",
                     go_cyc, ld_cyc, early, count);
        end
        tick();
        checks++;
        if (writes_seen - w0 !== 16 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL pad_writes: got writes=%0d left=%0d, required 16/0", writes_seen - w0, exp_q.size());
        end
    endtask

    task automatic test_gaps();
        int w0, go_cyc, ld_cyc;
        bit ok, all_ok, early;
        logic [7:0] d;
        w0 = writes_seen;
        all_ok = 1'b1;
        start_frame();
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'(8'h10 + i);
            exp_q.push_back({4'(i), d});
            drive_byte(d, 1'b0, 3, ok);
            all_ok &= ok;
        end
        checks++;
        if (!all_ok || count !== 5'd16 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL gaps_count: got ok=%0b count=%0d rdy=%0b, required 1/16/0", all_ok, count, in_ready);
        end
        complete_frame(3, go_cyc, ld_cyc, early);
        tick();
        checks++;
        if (go_cyc !== 1 || ld_cyc !== 1 || early || writes_seen - w0 !== 16 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL gaps_end: got go_cyc=%0d ld_cyc=%0d early=%0b writes=%0d left=%0d, required 1/1/0/16/0",
                     go_cyc, ld_cyc, early, writes_seen - w0, exp_q.size());
        end
    endtask

    task automatic test_long_wait();
        int go_cyc, ld_cyc;
        bit ok, all_ok, early;
        logic [7:0] d;
        all_ok = 1'b1;
        start_frame();
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'(8'h40 + 3 * i);
            exp_q.push_back({4'(i), d});
            drive_byte(d, 1'b0, 0, ok);
            all_ok &= ok;
        end
        complete_frame(50, go_cyc, ld_cyc, early);
        checks++;
        if (!all_ok || go_cyc !== 1 || early || ld_cyc !== 1) begin
            errors++;
            $display("FAIL wait_hold: got ok=%0b go_cyc=%0d early=%0b ld_cyc=%0d, required 1/1/0/1",
                     all_ok, go_cyc, early, ld_cyc);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || load_done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: got busy=%0b ld=%0b rdy=%0b, required 0/0/0", busy, load_done, in_ready);
        end
    endtask

    task automatic test_reset_midframe();
        int w0, g0, go_cyc, ld_cyc;
        bit ok, all_ok, early;
        logic [7:0] d;
        w0 = writes_seen;
        g0 = go_seen;
        all_ok = 1'b1;
        start_frame();
        for (int i = 0; i < 7; i++) begin
            d = 8'(8'h70 + i);
            exp_q.push_back({4'(i), d});
            drive_byte(d, 1'b0, 0, ok);
            all_ok &= ok;
        end
        Rst = 1'b1;
        tick();
        checks++;
        if ({in_ready, w_en, go, busy, load_done, w_addr, w_data, count} !== 22'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got rdy=%0b wen=%0b go=%0b busy=%0b ld=%0b addr=%0d data=%02h cnt=%0d, required all 0",
                     in_ready, w_en, go, busy, load_done, w_addr, w_data, count);
        end
        Rst = 1'b0;
        repeat (20) tick();
        checks++;
        if (!all_ok || go_seen !== g0 || writes_seen - w0 !== 7 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL midreset_abort: got ok=%0b go_delta=%0d writes=%0d left=%0d, required 1/0/7/0",
                     all_ok, go_seen - g0, writes_seen - w0, exp_q.size());
        end
        w0 = writes_seen;
        start_frame();
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'(8'h80 + i);
            exp_q.push_back({4'(i), d});
            drive_byte(d, 1'b0, 0, ok);
        end
        complete_frame(1, go_cyc, ld_cyc, early);
        tick();
        checks++;
        if (go_cyc !== 1 || ld_cyc !== 1 || writes_seen - w0 !== 16 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL midreset_reload: got go_cyc=%0d ld_cyc=%0d writes=%0d left=%0d, required 1/1/16/0",
                     go_cyc, ld_cyc, writes_seen - w0, exp_q.size());
        end
    endtask

    task automatic test_stray_controls();
        int w0, go_cyc, ld_cyc;
        bit ok, all_ok, early;
        logic [7:0] d;
        w0 = writes_seen;
        all_ok = 1'b1;
        start_frame();
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'(8'hC0 ^ (5 * i));
            exp_q.push_back({4'(i), d});
            if (i == 3) start = 1'b1;
            if (i == 8) done_in = 1'b1;
            drive_byte(d, 1'b0, 0, ok);
            start = 1'b0;
            done_in = 1'b0;
            all_ok &= ok;
        end
        checks++;
        if (!all_ok || count !== 5'd16) begin
            errors++;
            $display("FAIL stray_count: got ok=%0b count=%0d, required 1/16", all_ok, count);
        end
        complete_frame(1, go_cyc, ld_cyc, early);
        tick();
        checks++;
        if (go_cyc !== 1 || ld_cyc !== 1 || early || busy !== 1'b0 || writes_seen - w0 !== 16 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL stray_end: got go_cyc=%0d ld_cyc=%0d early=%0b busy=%0b writes=%0d left=%0d, required 1/1/0/0/16/0",
                     go_cyc, ld_cyc, early, busy, writes_seen - w0, exp_q.size());
        end
    endtask

    initial begin
        Rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        done_in  = 1'b0;
        test_reset();
        test_full_frame();
        test_pad();
        test_gaps();
        test_long_wait();
        test_reset_midframe();
        test_stray_controls();
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
